mem_stage: RTL and testbench

- Memory-access pipeline stage of the 5-stage MIPS core, between EX and WB.
- Registers the EX→MEM bus under stall control and extracts and extends load data from the synchronous data SRAM.
- Builds the MEM→WB bus consumed by the writeback stage, and a MEM→ID forwarding bus for GPR and HI/LO bypass.
- Holds load data stable across multi-cycle stalls.

---
 rtl/mem_stage_pkg.sv | 68 ++++++
 rtl/mem_stage_load_align.sv | 40 ++++
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Bus widths, stall encoding, load type codes and bus bundles.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 145;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_RF_WD = 104;
    localparam int STALL_WD     = 6;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    typedef struct packed {
        logic        we_hi;
        logic        we_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic [2:0]  ld_type;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    typedef struct packed {
        logic        we_hi;
        logic        we_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_wb_t;

    typedef struct packed {
        logic        we_hi;
        logic        we_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_rf_t;

    function automatic logic [31:0] ext8(input logic [7:0] b,
                                         input logic       sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h,
                                          input logic        sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks byte/half from SRAM word and extends it.
// Ports: rdata, offset[1:0], ld_type[2:0] in; data[31:0] out.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
    end

    // Halfword loads use offset[1] only; offset[0] is ignored.
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    // Unlisted codes fall back to a full-word load.
    always_comb begin
        data = rdata;
        unique case (1'b1)
            ld_type == LD_LB:  data = ext8(byte_sel, 1'b1);
            ld_type == LD_LBU: data = ext8(byte_sel, 1'b0);
            ld_type == LD_LH:  data = ext16(half_sel, 1'b1);
            ld_type == LD_LHU: data = ext16(half_sel, 1'b0);
            default:           data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM register, load extract, WB/forward buses.
// Ports: clk, rst, stall, ex_to_mem_bus, data_sram_rdata in;
//        mem_to_wb_bus, mem_to_rf_bus, mem_is_load out.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic                    mem_is_load
);

    ex_mem_t     r;
    logic        hold_valid;
    logic [31:0] hold_data;
    logic [31:0] ld_src;
    logic [31:0] ld_data;
    logic [31:0] rf_wdata;
    logic        ex_stop;
    logic        mem_stop;
    mem_wb_t     wb;
    mem_rf_t     fw;
    logic        unused_bits;

    assign ex_stop  = stall[STALL_EX] == STOP;
    assign mem_stop = stall[STALL_MEM] == STOP;

    assign mem_is_load = r.data_ram_en & r.sel_rf_res;

    // hold_data keeps the first read word of a stalled load, since
    // the SRAM output is only valid in the cycle the load arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r          <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (ex_stop && !mem_stop) begin
            r          <= '0;
            hold_valid <= 1'b0;
        end else if (!ex_stop) begin
            r          <= ex_mem_t'(ex_to_mem_bus);
            hold_valid <= 1'b0;
        end else if (mem_stop && mem_is_load && !hold_valid) begin
            hold_data  <= data_sram_rdata;
            hold_valid <= 1'b1;
        end
    end

    assign ld_src = hold_valid ? hold_data : data_sram_rdata;

    load_align u_align (
        .rdata   (ld_src),
        .offset  (r.ex_result[1:0]),
        .ld_type (r.ld_type),
        .data    (ld_data)
    );

    assign rf_wdata = r.sel_rf_res ? ld_data : r.ex_result;

    always_comb begin
        wb          = '0;
        wb.we_hi    = r.we_hi;
        wb.we_lo    = r.we_lo;
        wb.hi       = r.hi;
        wb.lo       = r.lo;
        wb.pc       = r.pc;
        wb.rf_we    = r.rf_we;
        wb.rf_waddr = r.rf_waddr;
        wb.rf_wdata = rf_wdata;
    end

    always_comb begin
        fw          = '0;
        fw.we_hi    = r.we_hi;
        fw.we_lo    = r.we_lo;
        fw.hi       = r.hi;
        fw.lo       = r.lo;
        fw.rf_we    = r.rf_we;
        fw.rf_waddr = r.rf_waddr;
        fw.rf_wdata = rf_wdata;
    end

    assign mem_to_wb_bus = wb;
    assign mem_to_rf_bus = fw;

    // Store strobes are consumed by EX; other stall bits belong elsewhere.
    assign unused_bits = ^{r.data_ram_wen, stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage.
// Vector table plus stall, bubble and async reset sequences.
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [144:0] ex_bus;
    logic [31:0]  rdata;
    logic [135:0] wb_bus;
    logic [103:0] rf_bus;
    logic         is_load;

    int total;
    int passed;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb_bus),
        .mem_to_rf_bus   (rf_bus),
        .mem_is_load     (is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we_hi;
        logic        we_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        en;
        logic [2:0]  ld;
        logic        sel;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] exr;
        logic [31:0] rd;
        logic [31:0] exp_wdata;
        logic        exp_load;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [144:0] pack(input vec_t v);
        return {v.we_hi, v.we_lo, v.hi, v.lo, v.pc, v.en, 4'b0000,
                v.ld, v.sel, v.rf_we, v.waddr, v.exr};
    endfunction

    function automatic logic [135:0] exp_wb(input vec_t v);
        return {v.we_hi, v.we_lo, v.hi, v.lo, v.pc, v.rf_we, v.waddr,
                v.exp_wdata};
    endfunction

    function automatic logic [103:0] exp_rf(input vec_t v);
        return {v.we_hi, v.we_lo, v.hi, v.lo, v.rf_we, v.waddr,
                v.exp_wdata};
    endfunction

    task automatic chk(input string name, input logic [135:0] act,
                       input logic [135:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        ex_bus = pack(v);
        rdata  = v.rd;
        stall  = 6'b000000;
        @(posedge clk);
        #1;
    endtask

    vec_t v;
    vec_t w;

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        stall  = '0;
        ex_bus = '0;
        rdata  = '0;

        //          we_hi we_lo hi lo pc en ld sel we wa exr rd exp load
        vecs[0]  = '{0, 0, 0, 0, 32'h0000_0100, 1, 3'd1, 1, 1, 5'd8,
                     32'h1000_0003, 32'h80FF_7F01, 32'hFFFF_FF80, 1};
        vecs[1]  = '{0, 0, 0, 0, 32'h0000_0104, 1, 3'd2, 1, 1, 5'd9,
                     32'h1000_0001, 32'h8001_FF02, 32'h0000_00FF, 1};
        vecs[2]  = '{0, 0, 0, 0, 32'h0000_0108, 1, 3'd4, 1, 1, 5'd10,
                     32'h1000_0002, 32'h8001_FF02, 32'h0000_8001, 1};
        vecs[3]  = '{0, 0, 0, 0, 32'h0000_010C, 1, 3'd3, 1, 1, 5'd11,
                     32'h1000_0000, 32'h8001_FF02, 32'hFFFF_FF02, 1};
        vecs[4]  = '{0, 0, 0, 0, 32'h0000_0110, 1, 3'd3, 1, 1, 5'd12,
                     32'h1000_0001, 32'h8001_FF02, 32'hFFFF_FF02, 1};
        vecs[5]  = '{1, 0, 32'hDEAD_BEEF, 32'h0000_0000, 32'hBFC0_0010,
                     0, 3'd0, 0, 1, 5'd3, 32'h1234_5678, 32'hFFFF_FFFF,
                     32'h1234_5678, 0};
        vecs[6]  = '{0, 0, 0, 0, 32'h0000_0118, 1, 3'd0, 1, 1, 5'd13,
                     32'h1000_0002, 32'h8001_FF02, 32'h8001_FF02, 1};
        vecs[7]  = '{0, 0, 0, 0, 32'h0000_011C, 1, 3'd6, 1, 1, 5'd14,
                     32'h1000_0001, 32'hCAFE_BABE, 32'hCAFE_BABE, 1};
        vecs[8]  = '{0, 1, 0, 32'h0BAD_F00D, 32'h0000_0120, 1, 3'd0, 0,
                     0, 5'd0, 32'h0000_0100, 32'h1111_1111,
                     32'h0000_0100, 0};
        vecs[9]  = '{0, 0, 0, 0, 32'h0000_0124, 1, 3'd1, 1, 1, 5'd15,
                     32'h1000_0001, 32'h80FF_7F01, 32'h0000_007F, 1};
        vecs[10] = '{0, 0, 0, 0, 32'h0000_0128, 1, 3'd2, 1, 1, 5'd16,
                     32'h1000_0003, 32'h80FF_7F01, 32'h0000_0080, 1};
        vecs[11] = '{0, 0, 0, 0, 32'h0000_012C, 1, 3'd3, 1, 1, 5'd17,
                     32'h1000_0002, 32'h80FF_7F01, 32'hFFFF_80FF, 1};
        vecs[12] = '{0, 0, 0, 0, 32'h0000_0130, 1, 3'd4, 1, 1, 5'd18,
                     32'h1000_0000, 32'h80FF_7F01, 32'h0000_7F01, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb", wb_bus, '0);
        chk("reset_rf", {32'd0, rf_bus}, '0);
        chk("reset_is_load", {135'd0, is_load}, '0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            chk($sformatf("vec%0d_wb", i), wb_bus, exp_wb(vecs[i]));
            chk($sformatf("vec%0d_rf", i), {32'd0, rf_bus},
                {32'd0, exp_rf(vecs[i])});
            chk($sformatf("vec%0d_is_load", i), {135'd0, is_load},
                {135'd0, vecs[i].exp_load});
        end

        // Stalled load keeps its first read word.
        v = vecs[6];
        v.exr = 32'h2000_0000;
        v.rd  = 32'hAAAA_AAAA;
        v.exp_wdata = 32'hAAAA_AAAA;
        apply(v);
        chk("hold_c0", wb_bus, exp_wb(v));
        stall = 6'b011111;
        @(posedge clk);
        #1;
        rdata = 32'h5555_5555;
        chk("hold_c1", wb_bus, exp_wb(v));
        chk("hold_valid_set", {135'd0, dut.hold_valid}, {135'd0, 1'b1});
        @(posedge clk);
        #1;
        rdata = 32'h0000_0000;
        chk("hold_c2", wb_bus, exp_wb(v));
        @(posedge clk);
        #1;
        chk("hold_c3", wb_bus, exp_wb(v));
        w = vecs[5];
        apply(w);
        chk("hold_release_valid", {135'd0, dut.hold_valid}, '0);
        chk("hold_release_wb", wb_bus, exp_wb(w));

        // Both stopped holds; EX stopped with MEM running bubbles.
        ex_bus = pack(vecs[0]);
        stall  = 6'b011111;
        @(posedge clk);
        #1;
        chk("stall_hold_prev", wb_bus, exp_wb(w));
        stall = 6'b001111;
        @(posedge clk);
        #1;
        chk("bubble_wb", wb_bus, '0);
        chk("bubble_rf", {32'd0, rf_bus}, '0);
        stall = 6'b011111;
        @(posedge clk);
        #1;
        chk("bubble_held", wb_bus, '0);

        // Async reset between edges, in the middle of a load stall.
        v = vecs[0];
        apply(v);
        chk("pre_reset_wb", wb_bus, exp_wb(v));
        stall = 6'b011111;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_wb", wb_bus, '0);
        chk("areset_rf", {32'd0, rf_bus}, '0);
        chk("areset_is_load", {135'd0, is_load}, '0);
        chk("areset_hold_valid", {135'd0, dut.hold_valid}, '0);
        chk("areset_hold_data", {104'd0, dut.hold_data}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
